sdram_arbiter: RTL and testbench

- Shares the single read port and single write port of the sdram controller between several independent requesters, e.g. video scanout, CPU and DMA.
- Each port has its own round-robin arbiter. Every granted read burst is recorded in a tag FIFO so that returning rd_rdy/rd_data words are steered to the client that issued the burst.
- Sits between the client masters and the sdram instance. Every signal on the sdram side matches the controller's rd_*/wr_* interface exactly.

---
 rtl/sdram_arb_pkg.sv | 21 ++
 rtl/sdram_arb_rr.sv | 28 ++
 rtl/sdram_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arbiter shared types and constants.
// Holds the burst tag layout and the arbiter state encoding.
package sdram_arb_pkg;

  localparam int LENW   = 4;
  localparam int AW_DEF = 20;
  localparam int DW_DEF = 16;
  // wide enough for up to 8 read clients
  localparam int CIW    = 3;

  typedef struct packed {
    logic [CIW-1:0]  client;
    logic [LENW-1:0] len;
  } tag_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_st_e;

endpackage

// File: rtl/sdram_arb_rr.sv
// Round-robin picker: lowest asserted req at or after ptr, wrapping.
// Ports: req[N] in, ptr in; gnt (index) out, vld out.
module sdram_arb_rr
  import sdram_arb_pkg::*;
#(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          vld
);

  always_comb begin
    int j;
    gnt = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!vld && req[j]) begin
        vld = 1'b1;
        gnt = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the sdram read/write ports among NRD/NWR clients.
// Ports: cr_*/cw_* client side, rd_*/wr_* controller side, err sticky.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NRD      = 3,
  parameter int NWR      = 2,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int TQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] cr_addr,
  input  logic [NRD*4-1:0]  cr_len,
  input  logic [NRD-1:0]    cr_req,
  output logic [NRD-1:0]    cr_ack,
  output logic [DW-1:0]     cr_data,
  output logic [NRD-1:0]    cr_rdy,
  input  logic [NWR*AW-1:0] cw_addr,
  input  logic [NWR*DW-1:0] cw_data,
  input  logic [NWR*4-1:0]  cw_len,
  input  logic [NWR-1:0]    cw_req,
  output logic [NWR-1:0]    cw_ack,
  output logic [AW-1:0]     rd_addr,
  output logic [3:0]        rd_len,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [DW-1:0]     rd_data,
  input  logic              rd_rdy,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [3:0]        wr_len,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic              err
);

  localparam int RPW = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int WPW = (NWR > 1) ? $clog2(NWR) : 1;
  localparam int QW  = $clog2(TQ_DEPTH);
  localparam int CW  = QW + 1;

  // read side state
  arb_st_e         rst_q, rst_d;
  logic [RPW-1:0]  rptr_q, rptr_d;
  logic [RPW-1:0]  rgnt_q, rgnt_d;
  logic [RPW-1:0]  rpick;
  logic            rvld;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [LENW-1:0] rlen_q, rlen_d;
  logic            rreq_q, rreq_d;
  logic            push;
  tag_t            push_tag;

  // write side state
  arb_st_e         wst_q, wst_d;
  logic [WPW-1:0]  wptr_q, wptr_d;
  logic [WPW-1:0]  wgnt_q, wgnt_d;
  logic [WPW-1:0]  wpick;
  logic            wvld;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [LENW-1:0] wlen_q, wlen_d;
  logic            wreq_q, wreq_d;

  // tag fifo
  tag_t            tq_q [TQ_DEPTH];
  tag_t            tq_d [TQ_DEPTH];
  logic [QW-1:0]   hd_q, hd_d;
  logic [QW-1:0]   tl_q, tl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            err_q, err_d;
  logic            tq_empty, tq_full, pop;

  sdram_arb_rr #(.N(NRD)) u_rd_rr (
    .req (cr_req),
    .ptr (rptr_q),
    .gnt (rpick),
    .vld (rvld)
  );

  sdram_arb_rr #(.N(NWR)) u_wr_rr (
    .req (cw_req),
    .ptr (wptr_q),
    .gnt (wpick),
    .vld (wvld)
  );

  assign tq_empty = (cnt_q == '0);
  assign tq_full  = (cnt_q == CW'(TQ_DEPTH));
  assign pop      = rd_rdy && !tq_empty
                 && (rem_q == '0);

  assign push_tag.client = CIW'(rgnt_q);
  assign push_tag.len    = rlen_q;

  always_comb begin
    rst_d   = rst_q;
    rptr_d  = rptr_q;
    rgnt_d  = rgnt_q;
    raddr_d = raddr_q;
    rlen_d  = rlen_q;
    rreq_d  = rreq_q;
    push    = 1'b0;
    unique case (rst_q)
      IDLE: begin
        if (rvld && !tq_full) begin
          rgnt_d  = rpick;
          raddr_d = cr_addr[rpick*AW +: AW];
          rlen_d  = cr_len[rpick*LENW +: LENW];
          rreq_d  = 1'b1;
          rst_d   = BUSY;
        end
      end
      BUSY: begin
        if (rd_ack) begin
          rreq_d = 1'b0;
          push   = 1'b1;
          rptr_d = (rgnt_q == RPW'(NRD-1))
                 ? '0 : rgnt_q + 1'b1;
          rst_d  = IDLE;
        end
      end
      default: rst_d = IDLE;
    endcase
  end

  always_comb begin
    wst_d   = wst_q;
    wptr_d  = wptr_q;
    wgnt_d  = wgnt_q;
    waddr_d = waddr_q;
    wlen_d  = wlen_q;
    wreq_d  = wreq_q;
    unique case (wst_q)
      IDLE: begin
        if (wvld) begin
          wgnt_d  = wpick;
          waddr_d = cw_addr[wpick*AW +: AW];
          wlen_d  = cw_len[wpick*LENW +: LENW];
          wreq_d  = 1'b1;
          wst_d   = BUSY;
        end
      end
      BUSY: begin
        if (wr_ack) begin
          wreq_d = 1'b0;
          wptr_d = (wgnt_q == WPW'(NWR-1))
                 ? '0 : wgnt_q + 1'b1;
          wst_d  = IDLE;
        end
      end
      default: wst_d = IDLE;
    endcase
  end

  // rem_q counts words still owed to the head burst;
  // it is reloaded whenever a new tag becomes head.
  always_comb begin
    tq_d  = tq_q;
    hd_d  = hd_q;
    tl_d  = tl_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    err_d = err_q | (rd_rdy & tq_empty);
    if (push) begin
      tq_d[tl_q] = push_tag;
      tl_d       = tl_q + 1'b1;
    end
    if (pop) hd_d = hd_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    if (pop) begin
      if (cnt_q > CW'(1))
        rem_d = tq_q[hd_q + 1'b1].len;
      else if (push)
        rem_d = push_tag.len;
    end else if (rd_rdy && !tq_empty) begin
      rem_d = rem_q - 1'b1;
    end else if (tq_empty && push) begin
      rem_d = push_tag.len;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      cr_ack[i] = rd_ack && (rst_q == BUSY)
               && (rgnt_q == RPW'(i));
      cr_rdy[i] = rd_rdy && !tq_empty
               && (tq_q[hd_q].client == CIW'(i));
    end
    for (int i = 0; i < NWR; i++) begin
      cw_ack[i] = wr_ack && (wst_q == BUSY)
               && (wgnt_q == WPW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q   <= IDLE;
      rptr_q  <= '0;
      rgnt_q  <= '0;
      raddr_q <= '0;
      rlen_q  <= '0;
      rreq_q  <= 1'b0;
      wst_q   <= IDLE;
      wptr_q  <= '0;
      wgnt_q  <= '0;
      waddr_q <= '0;
      wlen_q  <= '0;
      wreq_q  <= 1'b0;
      for (int i = 0; i < TQ_DEPTH; i++)
        tq_q[i] <= '0;
      hd_q    <= '0;
      tl_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      rst_q   <= rst_d;
      rptr_q  <= rptr_d;
      rgnt_q  <= rgnt_d;
      raddr_q <= raddr_d;
      rlen_q  <= rlen_d;
      rreq_q  <= rreq_d;
      wst_q   <= wst_d;
      wptr_q  <= wptr_d;
      wgnt_q  <= wgnt_d;
      waddr_q <= waddr_d;
      wlen_q  <= wlen_d;
      wreq_q  <= wreq_d;
      tq_q    <= tq_d;
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign rd_addr = raddr_q;
  assign rd_len  = rlen_q;
  assign rd_req  = rreq_q;
  assign wr_addr = waddr_q;
  assign wr_len  = wlen_q;
  assign wr_req  = wreq_q;
  assign wr_data = cw_data[wgnt_q*DW +: DW];
  assign cr_data = rd_data;
  assign err     = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter.
// Bench plays the controller by hand on rd_*/wr_*.
module tb_sdram_arbiter;

  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int AW  = 20;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] cr_addr;
  logic [NRD*4-1:0]  cr_len;
  logic [NRD-1:0]    cr_req;
  logic [NRD-1:0]    cr_ack;
  logic [DW-1:0]     cr_data;
  logic [NRD-1:0]    cr_rdy;
  logic [NWR*AW-1:0] cw_addr;
  logic [NWR*DW-1:0] cw_data;
  logic [NWR*4-1:0]  cw_len;
  logic [NWR-1:0]    cw_req;
  logic [NWR-1:0]    cw_ack;
  logic [AW-1:0]     rd_addr;
  logic [3:0]        rd_len;
  logic              rd_req;
  logic              rd_ack;
  logic [DW-1:0]     rd_data;
  logic              rd_rdy;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [3:0]        wr_len;
  logic              wr_req;
  logic              wr_ack;
  logic              err;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NRD(NRD), .NWR(NWR), .AW(AW),
    .DW(DW), .TQ_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cr_addr(cr_addr), .cr_len(cr_len),
    .cr_req(cr_req), .cr_ack(cr_ack),
    .cr_data(cr_data), .cr_rdy(cr_rdy),
    .cw_addr(cw_addr), .cw_data(cw_data),
    .cw_len(cw_len), .cw_req(cw_req),
    .cw_ack(cw_ack),
    .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_rdy(rd_rdy),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_len(wr_len), .wr_req(wr_req),
    .wr_ack(wr_ack), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cr_addr = '0; cr_len = '0; cr_req = '0;
    cw_addr = '0; cw_data = '0;
    cw_len  = '0; cw_req = '0;
    rd_ack  = 1'b0; rd_data = '0; rd_rdy = 1'b0;
    wr_ack  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One read grant: ack it, drop the client's req
  // for the gap cycle, optionally return one word.
  task automatic grant(input int c,
                       input logic [AW-1:0] a,
                       input bit ret,
                       input logic [NRD-1:0] rdy);
    chk("rd_req_up", rd_req, 1);
    chk("rd_addr", rd_addr, a);
    rd_ack = 1'b1;
    #1;
    chk("cr_ack", cr_ack, 64'(1) << c);
    tick();
    rd_ack    = 1'b0;
    cr_req[c] = 1'b0;
    rd_rdy    = ret;
    #1;
    chk("rd_req_gap", rd_req, 0);
    chk("cr_ack_off", cr_ack, 0);
    if (ret) chk("gap_rdy", cr_rdy, rdy);
    tick();
    rd_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #1;
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_len", wr_len, 0);
    chk("rst_cr_ack", cr_ack, 0);
    chk("rst_cw_ack", cw_ack, 0);
    chk("rst_cr_rdy", cr_rdy, 0);
    chk("rst_err", err, 0);

    // single read, client 1, len 3
    cr_addr[1*AW +: AW] = 20'h00100;
    cr_len[1*4 +: 4]    = 4'd3;
    cr_req              = 3'b010;
    #1;
    chk("t1_no_req_yet", rd_req, 0);
    tick();
    chk("t1_rd_len", rd_len, 3);
    grant(1, 20'h00100, 0, '0);
    for (int k = 0; k < 4; k++) begin
      rd_rdy  = 1'b1;
      rd_data = 16'hA000 + 16'(k);
      #1;
      chk("t1_rdy", cr_rdy, 3'b010);
      chk("t1_data", cr_data, 16'hA000 + k);
      tick();
    end
    rd_rdy = 1'b0;
    #1;
    chk("t1_rdy_off", cr_rdy, 0);
    chk("t1_err", err, 0);

    // all clients requesting, len 0
    do_reset();
    for (int i = 0; i < NRD; i++)
      cr_addr[i*AW +: AW] = 20'h10 + 20'(i);
    cr_req = 3'b111;
    tick();
    for (int k = 0; k < 6; k++) begin
      grant(k % 3, 20'h10 + 20'(k % 3),
            1, 3'(1 << (k % 3)));
      cr_req[k % 3] = 1'b1;
    end

    // overlapping len-15 bursts, clients 0 and 2
    do_reset();
    cr_addr[0*AW +: AW] = 20'h00200;
    cr_addr[2*AW +: AW] = 20'h00300;
    cr_len = {4'd15, 4'd0, 4'd15};
    cr_req = 3'b101;
    tick();
    grant(0, 20'h00200, 0, '0);
    grant(2, 20'h00300, 0, '0);
    cr_req = '0;
    for (int k = 0; k < 32; k++) begin
      rd_rdy  = 1'b1;
      rd_data = 16'(k);
      #1;
      chk("t3_route", cr_rdy,
          (k < 16) ? 3'b001 : 3'b100);
      tick();
    end
    rd_rdy = 1'b0;
    #1;
    chk("t3_err", err, 0);

    // tag fifo full blocks a 5th grant
    do_reset();
    for (int i = 0; i < NRD; i++)
      cr_addr[i*AW +: AW] = 20'h10 + 20'(i);
    cr_req = 3'b111;
    tick();
    grant(0, 20'h10, 0, '0); cr_req[0] = 1'b1;
    grant(1, 20'h11, 0, '0); cr_req[1] = 1'b1;
    grant(2, 20'h12, 0, '0); cr_req[2] = 1'b1;
    grant(0, 20'h10, 0, '0); cr_req[0] = 1'b1;
    #1;
    chk("t4_full0", rd_req, 0);
    tick();
    chk("t4_full1", rd_req, 0);
    tick();
    chk("t4_full2", rd_req, 0);
    rd_rdy = 1'b1;
    #1;
    chk("t4_pop_rdy", cr_rdy, 3'b001);
    tick();
    rd_rdy = 1'b0;
    #1;
    chk("t4_still_off", rd_req, 0);
    tick();
    chk("t4_5th_req", rd_req, 1);
    chk("t4_5th_addr", rd_addr, 20'h11);

    // stray rd_rdy with empty fifo
    do_reset();
    rd_rdy = 1'b1;
    #1;
    chk("t5_no_rdy", cr_rdy, 0);
    tick();
    rd_rdy = 1'b0;
    #1;
    chk("t5_err_set", err, 1);
    tick();
    tick();
    chk("t5_err_stuck", err, 1);
    do_reset();
    #1;
    chk("t5_err_clr", err, 0);
    chk("t5_rd_req", rd_req, 0);

    // concurrent read and write
    cw_addr[1*AW +: AW] = 20'h00555;
    cw_data[1*DW +: DW] = 16'hBEEF;
    cw_data[0*DW +: DW] = 16'h1111;
    cw_len[1*4 +: 4]    = 4'd2;
    cr_addr[0*AW +: AW] = 20'h000AA;
    cw_req = 2'b10;
    cr_req = 3'b001;
    tick();
    chk("t6_wr_req", wr_req, 1);
    chk("t6_rd_req", rd_req, 1);
    chk("t6_wr_addr", wr_addr, 20'h00555);
    chk("t6_wr_len", wr_len, 2);
    chk("t6_rd_addr", rd_addr, 20'h000AA);
    chk("t6_wr_data0", wr_data, 16'hBEEF);
    tick();
    chk("t6_wr_data1", wr_data, 16'hBEEF);
    chk("t6_cw_ack0", cw_ack, 0);
    wr_ack = 1'b1;
    #1;
    chk("t6_cw_ack", cw_ack, 2'b10);
    chk("t6_cr_ack0", cr_ack, 0);
    tick();
    wr_ack = 1'b0;
    cw_req = '0;
    rd_ack = 1'b1;
    #1;
    chk("t6_wr_drop", wr_req, 0);
    chk("t6_cw_off", cw_ack, 0);
    chk("t6_cr_ack", cr_ack, 3'b001);
    tick();
    rd_ack = 1'b0;
    cr_req = '0;
    #1;
    chk("t6_rd_drop", rd_req, 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
